nx_stat_counter_bank: RTL and testbench
=======================================

Name: nx_stat_counter_bank

Overview:
Bank of N_ENTRIES hardware event counters feeding the read-only indirect register block's mem_a array. Per-entry increments accumulate into live counters. On a software- or hardware-issued snapshot, all live values are copied atomically into a shadow array driven out on mem_a, so indirect reads see a coherent set. A sequential clear sweep zeroes the live counters without dropping events.

Parameters:
N_ENTRIES, 32, number of counters; must be a power of two, at least 2
N_DATA_BITS, 64, counter and mem_a entry width
N_INC_BITS, 4, width of each per-entry increment value

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
evt_vld  input  N_ENTRIES  per-entry increment valid
evt_inc  input  N_ENTRIES*N_INC_BITS  per-entry increment amount; entry i at bits [i*N_INC_BITS +: N_INC_BITS]
snap_req  input  1  single-cycle snapshot request pulse
clr_req  input  1  single-cycle clear-all request pulse
mem_a  output  N_DATA_BITS x [0:N_ENTRIES-1]  shadow (snapshot) array; connects to the indirect access block
snap_done  output  1  one-cycle pulse when a snapshot has been written into mem_a
clr_busy  output  1  high while the clear sweep is in progress
sat_any  output  1  sticky; set when any live counter saturates; cleared by reset or by sweep completion

Behaviour:
- One clock domain; reset is synchronous and active-high. All state updates on posedge clk.
- Reset values: every live counter = 0; every mem_a entry = 0; snap_done = 0; clr_busy = 0; sat_any = 0; FSM = IDLE; snapshot-pending flag = 0; sweep index = 0.
- Counter update, every cycle, for each entry i:
  - If evt_vld[i], live[i] <= live[i] + zero-extended inc[i].
  - Arithmetic saturates at all-ones and never wraps. If a sum would exceed all-ones, the counter holds all-ones and sat_any is set.
  - An increment of 0 with evt_vld = 1 is a no-op.
- FSM states: IDLE, SNAP, CLEAR.
- IDLE:
  - clr_req -> CLEAR, sweep index = 0, clr_busy = 1 from the next cycle.
  - snap_req without clr_req -> SNAP.
  - snap_req and clr_req in the same cycle: the snapshot is taken first (-> SNAP) and the clear is queued. After SNAP the FSM goes to CLEAR.
- SNAP (one cycle):
  - mem_a[i] <= live[i] for all i, using the post-increment value for that edge, so an event in the SNAP cycle is included.
  - snap_done pulses on the following cycle. Snapshot latency from snap_req = 2 cycles to mem_a update, 3 to the snap_done pulse.
  - Then -> CLEAR if a clear is queued, else IDLE.
- CLEAR:
  - Each cycle, live[idx] <= (evt_vld[idx] ? zero-extended inc[idx] : 0), so an event on the entry being cleared is retained. idx increments.
  - Entries not yet swept, or already swept, keep counting normally.
  - After idx = N_ENTRIES-1: -> IDLE, clr_busy drops on the next cycle, sat_any is cleared. Sweep duration = N_ENTRIES cycles.
- Requests during CLEAR:
  - snap_req sets the pending flag. It is serviced by entering SNAP immediately after CLEAR completes.
  - A further clr_req is ignored.
- Requests during SNAP: a further snap_req is merged (no extra snapshot); clr_req is queued.
- mem_a changes only in SNAP (and reset). It is constant otherwise, so indirect reads between snapshots are stable.
- Reset asserted mid-sweep or mid-snapshot:
  - All state returns to reset values on that edge.
  - Pending and queued requests are discarded.
  - Requests presented while reset is high are ignored.

Optional Feature:
NX_STAT_CLR_ON_SNAP_EN:
- Defined:
  - In SNAP, each live[i] is additionally loaded with (evt_vld[i] ? inc[i] : 0) on the same edge that copies it to mem_a. This gives atomic read-and-clear with no lost events.
  - sat_any is cleared in SNAP unless a saturation occurs in that cycle.
- Undefined: SNAP leaves the live counters untouched.

Test Plan:
- Reset, then entry 3 gets evt_inc=5 for 4 cycles; pulse snap_req -> mem_a[3]=20, all other entries 0; snap_done exactly 3 cycles after snap_req.
- Preload entry 0 to all-ones minus 2 via increments; apply inc=15 -> live[0] = all-ones, sat_any=1; the next snapshot shows mem_a[0]=64'hFFFF_FFFF_FFFF_FFFF.
- Counters at 10 each; pulse clr_req; hold evt_inc=1 on entry 7 during the sweep -> clr_busy high for 32 cycles; the following snapshot shows entry 7 = (number of cycles after idx 7 was swept, +1); all others 0.
- snap_req and clr_req in the same cycle with entry 2 = 9 -> mem_a[2]=9, then the sweep runs; a later snapshot shows 0.
- snap_req at sweep idx 10 -> no mem_a change until the sweep ends; then a single snapshot and a single snap_done pulse.
- Assert reset at sweep idx 5 -> next cycle clr_busy=0, all counters 0, mem_a 0, no snap_done; with NX_STAT_CLR_ON_SNAP_EN, snapshot of entry 1=6 -> mem_a[1]=6 and live[1]=0 afterwards.

Source files
------------

// File: rtl/nx_stat_counter_bank.sv
// nx_stat_counter_bank: a bank of saturating event counters. A snapshot copies
//   them as one coherent set into the shadow array mem_a, and a sequential
//   clear sweep zeroes them one entry per cycle without dropping events.
// Latency: snap_req -> mem_a update 2 cycles, -> snap_done pulse 3 cycles;
//   clr_req -> clr_busy 1 cycle, sweep lasts N_ENTRIES cycles.
// Backpressure: none. Requests that cannot be serviced at once are held as a
//   pending snapshot or a queued clear. Repeat requests are merged or dropped.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   evt_vld, evt_inc     per-entry increment valid and amount (entry i at [i*N_INC_BITS +: N_INC_BITS])
//   snap_req, clr_req    single-cycle snapshot and clear-all requests
//   mem_a                shadow array read by the indirect access block
//   snap_done            one-cycle pulse after mem_a has been written
//   clr_busy             high while the clear sweep runs
//   sat_any              sticky saturation flag
//
// Optional build macro NX_STAT_CLR_ON_SNAP_EN: when defined, a snapshot also
// clears the live counters on the same edge (atomic read-and-clear).

module nx_stat_counter_bank #(
  parameter int N_ENTRIES   = 32,
  parameter int N_DATA_BITS = 64,
  parameter int N_INC_BITS  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_ENTRIES-1:0]            evt_vld,
  input  logic [N_ENTRIES*N_INC_BITS-1:0] evt_inc,
  input  logic                            snap_req,
  input  logic                            clr_req,
  output logic [N_DATA_BITS-1:0]          mem_a [0:N_ENTRIES-1],
  output logic                            snap_done,
  output logic                            clr_busy,
  output logic                            sat_any
);

  localparam int IDX_W = $clog2(N_ENTRIES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNAP  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              snap_pend, snap_pend_nxt;
  logic              clr_q, clr_q_nxt;
  logic              snap_wr;
  logic              sweep_done;

  logic [N_DATA_BITS-1:0] live     [N_ENTRIES];
  logic [N_DATA_BITS-1:0] live_sum [N_ENTRIES];  // saturating post-increment value
  logic [N_DATA_BITS-1:0] clr_val  [N_ENTRIES];  // value an entry takes when cleared
  logic [N_DATA_BITS-1:0] inc_ext  [N_ENTRIES];
  logic [N_DATA_BITS:0]   sum_ext  [N_ENTRIES];  // one extra bit catches overflow
  logic [N_ENTRIES-1:0]   sat_vec;

  assign sweep_done = (state == ST_CLEAR) && (idx == IDX_W'(N_ENTRIES - 1));
  assign clr_busy   = (state == ST_CLEAR);

  // Per-entry increment datapath.
  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      inc_ext[i]  = N_DATA_BITS'(evt_inc[i*N_INC_BITS +: N_INC_BITS]);
      sum_ext[i]  = {1'b0, live[i]} + {1'b0, inc_ext[i]};
      sat_vec[i]  = evt_vld[i] & sum_ext[i][N_DATA_BITS];
      clr_val[i]  = evt_vld[i] ? inc_ext[i] : '0;
      if (!evt_vld[i]) begin
        live_sum[i] = live[i];
      end else if (sum_ext[i][N_DATA_BITS]) begin
        live_sum[i] = {N_DATA_BITS{1'b1}};
      end else begin
        live_sum[i] = sum_ext[i][N_DATA_BITS-1:0];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    snap_pend_nxt = snap_pend;
    clr_q_nxt     = clr_q;
    case (state)
      ST_IDLE: begin
        if (snap_req) begin
          // Snapshot wins a same-cycle tie; the clear runs right after it.
          state_nxt = ST_SNAP;
          clr_q_nxt = clr_req;
        end else if (clr_req) begin
          state_nxt = ST_CLEAR;
          idx_nxt   = '0;
        end
      end
      ST_SNAP: begin
        // A snap_req seen here is merged into the snapshot in progress.
        snap_pend_nxt = 1'b0;
        if (clr_q || clr_req) begin
          state_nxt = ST_CLEAR;
          idx_nxt   = '0;
          clr_q_nxt = 1'b0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // A clr_req seen here is dropped; the running sweep covers it.
        idx_nxt = idx + 1'b1;
        if (snap_req) snap_pend_nxt = 1'b1;
        if (sweep_done) begin
          idx_nxt = '0;
          if (snap_pend || snap_req) begin
            state_nxt     = ST_SNAP;
            snap_pend_nxt = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      snap_pend <= 1'b0;
      clr_q     <= 1'b0;
      snap_wr   <= 1'b0;
      snap_done <= 1'b0;
      sat_any   <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      snap_pend <= snap_pend_nxt;
      clr_q     <= clr_q_nxt;
      snap_wr   <= (state == ST_SNAP);
      snap_done <= snap_wr;
      // A saturation on the clearing edge itself is kept rather than lost.
      if (sweep_done) begin
        sat_any <= |sat_vec;
`ifdef NX_STAT_CLR_ON_SNAP_EN
      end else if (state == ST_SNAP) begin
        sat_any <= |sat_vec;
`endif
      end else if (|sat_vec) begin
        sat_any <= 1'b1;
      end
    end
  end

  // Live counters and shadow array.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        live[i]  <= '0;
        mem_a[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        // The swept entry keeps this cycle's event so nothing is lost.
        if ((state == ST_CLEAR) && (idx == IDX_W'(i))) begin
          live[i] <= clr_val[i];
`ifdef NX_STAT_CLR_ON_SNAP_EN
        end else if (state == ST_SNAP) begin
          live[i] <= clr_val[i];
`endif
        end else begin
          live[i] <= live_sum[i];
        end
        // The shadow copy includes the event arriving on the snapshot edge.
        if (state == ST_SNAP) mem_a[i] <= live_sum[i];
      end
    end
  end

endmodule

// File: tb/tb_nx_stat_counter_bank.sv
module tb_nx_stat_counter_bank;

  localparam int N  = 32;
  localparam int DW = 64;
  localparam int IW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      evt_vld;
  logic [N*IW-1:0]   evt_inc;
  logic              snap_req;
  logic              clr_req;
  logic [DW-1:0]     mem_a [0:N-1];
  logic              snap_done;
  logic              clr_busy;
  logic              sat_any;

  // Narrow-counter instance sharing the same stimulus, so saturation is reachable.
  logic [7:0]        mem_a8 [0:N-1];
  logic              snap_done8;
  logic              clr_busy8;
  logic              sat_any8;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  nx_stat_counter_bank #(.N_ENTRIES(N), .N_DATA_BITS(DW), .N_INC_BITS(IW)) dut (
    .clk(clk), .reset(reset), .evt_vld(evt_vld), .evt_inc(evt_inc),
    .snap_req(snap_req), .clr_req(clr_req), .mem_a(mem_a),
    .snap_done(snap_done), .clr_busy(clr_busy), .sat_any(sat_any)
  );

  nx_stat_counter_bank #(.N_ENTRIES(N), .N_DATA_BITS(8), .N_INC_BITS(IW)) dut8 (
    .clk(clk), .reset(reset), .evt_vld(evt_vld), .evt_inc(evt_inc),
    .snap_req(snap_req), .clr_req(clr_req), .mem_a(mem_a8),
    .snap_done(snap_done8), .clr_busy(clr_busy8), .sat_any(sat_any8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_evt(input int idx, input int val);
    evt_vld[idx] = 1'b1;
    evt_inc[idx*IW +: IW] = IW'(val);
  endtask

  task automatic clr_evt();
    evt_vld = '0;
    evt_inc = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; snap_req = 1'b0; clr_req = 1'b0; clr_evt();
    tick(); tick();
    reset = 1'b0;
  endtask

  // Expected snapshot: entry idx holds val, every other entry holds rest.
  task automatic push_exp(input int idx, input logic [DW-1:0] val, input logic [DW-1:0] rest);
    for (int i = 0; i < N; i++) exp_q.push_back((i == idx) ? val : rest);
  endtask

  // Pulses snap_req (optionally with clr_req) and waits for snap_done.
  // lat is the cycle count from the request to the pulse, -1 on timeout.
  task automatic pulse_snap(input logic with_clr, output int lat);
    snap_req = 1'b1; clr_req = with_clr;
    tick();
    snap_req = 1'b0; clr_req = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      if (snap_done === 1'b1) begin
        lat = k;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] exp_v;
    do_reset();
    n_checks++; if (snap_done !== 1'b0) begin n_fail++; $display("FAIL rst_snap_done got %b want 0", snap_done); end
    n_checks++; if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL rst_clr_busy got %b want 0", clr_busy); end
    n_checks++; if (sat_any !== 1'b0) begin n_fail++; $display("FAIL rst_sat_any got %b want 0", sat_any); end
    n_checks++; if (clr_busy8 !== 1'b0) begin n_fail++; $display("FAIL rst_clr_busy8 got %b want 0", clr_busy8); end
    exp_v = '0;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (mem_a[i] !== exp_v) begin n_fail++; $display("FAIL rst_mem_a[%0d] got %0h want %0h", i, mem_a[i], exp_v); end
    end
  endtask

  task automatic test_basic_snapshot();
    int lat;
    logic [DW-1:0] exp_v;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_evt(3, 5);
      tick();
    end
    clr_evt();
    push_exp(3, 64'd20, 64'd0);
    pulse_snap(1'b0, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency got %0d want 3", lat); end
    for (int i = 0; i < N; i++) begin
      exp_v = exp_q.pop_front(); n_checks++;
      if (mem_a[i] !== exp_v) begin n_fail++; $display("FAIL basic_mem_a[%0d] got %0h want %0h", i, mem_a[i], exp_v); end
    end
    tick();
    n_checks++; if (snap_done !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width got %b want 0", snap_done); end
  endtask

  task automatic test_saturation();
    int lat;
    logic [DW-1:0] exp_v;
    logic [7:0] exp8;
    do_reset();
    // 16*15 + 13 = 253 = 8'hFD, all-ones minus 2 in the narrow instance.
    for (int k = 0; k < 16; k++) begin
      set_evt(0, 15);
      tick();
    end
    set_evt(0, 13); tick();
    clr_evt();
    n_checks++; if (sat_any8 !== 1'b0) begin n_fail++; $display("FAIL sat_before got %b want 0", sat_any8); end
    set_evt(0, 15); tick();
    clr_evt();
    n_checks++; if (sat_any8 !== 1'b1) begin n_fail++; $display("FAIL sat_set got %b want 1", sat_any8); end
    n_checks++; if (sat_any !== 1'b0) begin n_fail++; $display("FAIL sat_wide got %b want 0", sat_any); end
    set_evt(0, 15); tick();
    clr_evt();
    push_exp(0, 64'd283, 64'd0);
    pulse_snap(1'b0, lat);
    n_checks++; if (snap_done8 !== 1'b1) begin n_fail++; $display("FAIL sat_snap_done8 got %b want 1", snap_done8); end
    for (int i = 0; i < N; i++) begin
      exp8 = (i == 0) ? 8'hFF : 8'h00; n_checks++;
      if (mem_a8[i] !== exp8) begin n_fail++; $display("FAIL sat_mem_a8[%0d] got %0h want %0h", i, mem_a8[i], exp8); end
    end
    for (int i = 0; i < N; i++) begin
      exp_v = exp_q.pop_front(); n_checks++;
      if (mem_a[i] !== exp_v) begin n_fail++; $display("FAIL sat_mem_a[%0d] got %0h want %0h", i, mem_a[i], exp_v); end
    end
  endtask

  task automatic test_clear_sweep();
    int lat;
    int busy;
    logic [DW-1:0] exp_v;
    do_reset();
    for (int i = 0; i < N; i++) set_evt(i, 10);
    tick();
    clr_evt();
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    busy = 0;
    // Entry 7 counts every sweep cycle; it is reloaded with 1 on the 8th.
    while (clr_busy === 1'b1 && busy < 100) begin
      clr_evt(); set_evt(7, 1);
      tick(); busy++;
    end
    clr_evt();
    n_checks++; if (busy !== 32) begin n_fail++; $display("FAIL sweep_busy_cycles got %0d want 32", busy); end
    push_exp(7, 64'd25, 64'd0);
    pulse_snap(1'b0, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sweep_snap_latency got %0d want 3", lat); end
    for (int i = 0; i < N; i++) begin
      exp_v = exp_q.pop_front(); n_checks++;
      if (mem_a[i] !== exp_v) begin n_fail++; $display("FAIL sweep_mem_a[%0d] got %0h want %0h", i, mem_a[i], exp_v); end
    end
  endtask

  task automatic test_snap_and_clear();
    int lat;
    int guard;
    logic [DW-1:0] exp_v;
    do_reset();
    set_evt(2, 9); tick();
    clr_evt();
    push_exp(2, 64'd9, 64'd0);
    pulse_snap(1'b1, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL both_latency got %0d want 3", lat); end
    for (int i = 0; i < N; i++) begin
      exp_v = exp_q.pop_front(); n_checks++;
      if (mem_a[i] !== exp_v) begin n_fail++; $display("FAIL both_mem_a[%0d] got %0h want %0h", i, mem_a[i], exp_v); end
    end
    n_checks++; if (clr_busy !== 1'b1) begin n_fail++; $display("FAIL both_clr_busy got %b want 1", clr_busy); end
    guard = 0;
    while (clr_busy === 1'b1 && guard < 100) begin tick(); guard++; end
    n_checks++; if (guard >= 100) begin n_fail++; $display("FAIL both_sweep_end got busy want idle"); end
    push_exp(2, 64'd0, 64'd0);
    pulse_snap(1'b0, lat);
    for (int i = 0; i < N; i++) begin
      exp_v = exp_q.pop_front(); n_checks++;
      if (mem_a[i] !== exp_v) begin n_fail++; $display("FAIL both_after_mem_a[%0d] got %0h want %0h", i, mem_a[i], exp_v); end
    end
  endtask

  task automatic test_snap_during_clear();
    int lat;
    int c;
    int pulses;
    logic changed;
    logic [DW-1:0] exp_v;
    do_reset();
    for (int i = 0; i < N; i++) set_evt(i, 3);
    tick();
    clr_evt();
    push_exp(0, 64'd3, 64'd3);
    pulse_snap(1'b0, lat);
    for (int i = 0; i < N; i++) begin
      exp_v = exp_q.pop_front(); n_checks++;
      if (mem_a[i] !== exp_v) begin n_fail++; $display("FAIL mid_pre_mem_a[%0d] got %0h want %0h", i, mem_a[i], exp_v); end
    end
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    c = 0; changed = 1'b0; pulses = 0;
    while (clr_busy === 1'b1 && c < 100) begin
      clr_evt();
      snap_req = (c == 10);
      if (c == 10) push_exp(4, 64'd2, 64'd0);
      if (c == 2) set_evt(20, 3);   // lands before entry 20 is swept: lost to the clear
      if (c == 14) set_evt(4, 2);   // lands after entry 4 is swept: kept
      tick(); c++;
      for (int i = 0; i < N; i++) if (mem_a[i] !== 64'd3) changed = 1'b1;
      if (snap_done === 1'b1) pulses++;
    end
    clr_evt(); snap_req = 1'b0;
    n_checks++; if (c !== 32) begin n_fail++; $display("FAIL mid_sweep_len got %0d want 32", c); end
    n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL mid_mem_stable got changed want stable"); end
    for (int k = 0; k < 12; k++) begin
      if (snap_done === 1'b1) begin
        pulses++;
        for (int i = 0; i < N; i++) begin
          exp_v = exp_q.pop_front(); n_checks++;
          if (mem_a[i] !== exp_v) begin n_fail++; $display("FAIL mid_mem_a[%0d] got %0h want %0h", i, mem_a[i], exp_v); end
        end
      end
      tick();
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL mid_snap_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_reset_mid_sweep();
    int lat;
    int bad;
    logic [DW-1:0] exp_v;
    do_reset();
    for (int i = 0; i < N; i++) set_evt(i, 4);
    tick();
    clr_evt();
    pulse_snap(1'b0, lat);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      snap_req = (c == 2);  // leaves a snapshot pending
      tick();
    end
    snap_req = 1'b1; clr_req = 1'b1; reset = 1'b1;
    tick();
    n_checks++; if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_clr_busy got %b want 0", clr_busy); end
    n_checks++; if (snap_done !== 1'b0) begin n_fail++; $display("FAIL rmid_snap_done got %b want 0", snap_done); end
    bad = 0;
    for (int i = 0; i < N; i++) if (mem_a[i] !== 64'd0) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rmid_mem_a_zero got %0d nonzero want 0", bad); end
    tick();
    reset = 1'b0; snap_req = 1'b0; clr_req = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (snap_done !== 1'b0 || clr_busy !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rmid_quiet got %0d active cycles want 0", bad); end
    push_exp(0, 64'd0, 64'd0);
    pulse_snap(1'b0, lat);
    for (int i = 0; i < N; i++) begin
      exp_v = exp_q.pop_front(); n_checks++;
      if (mem_a[i] !== exp_v) begin n_fail++; $display("FAIL rmid_mem_a[%0d] got %0h want %0h", i, mem_a[i], exp_v); end
    end
  endtask

  task automatic test_clr_on_snap();
    int lat;
    logic [DW-1:0] exp_v;
    do_reset();
    set_evt(1, 6); tick();
    clr_evt();
    push_exp(1, 64'd6, 64'd0);
    pulse_snap(1'b0, lat);
    for (int i = 0; i < N; i++) begin
      exp_v = exp_q.pop_front(); n_checks++;
      if (mem_a[i] !== exp_v) begin n_fail++; $display("FAIL cos_first_mem_a[%0d] got %0h want %0h", i, mem_a[i], exp_v); end
    end
`ifdef NX_STAT_CLR_ON_SNAP_EN
    push_exp(1, 64'd0, 64'd0);
`else
    push_exp(1, 64'd6, 64'd0);
`endif
    pulse_snap(1'b0, lat);
    for (int i = 0; i < N; i++) begin
      exp_v = exp_q.pop_front(); n_checks++;
      if (mem_a[i] !== exp_v) begin n_fail++; $display("FAIL cos_second_mem_a[%0d] got %0h want %0h", i, mem_a[i], exp_v); end
    end
  endtask

  initial begin
    reset = 1'b1; snap_req = 1'b0; clr_req = 1'b0;
    evt_vld = '0; evt_inc = '0;
    test_reset();
    test_basic_snapshot();
    test_saturation();
    test_clear_sweep();
    test_snap_and_clear();
    test_snap_during_clear();
    test_reset_mid_sweep();
    test_clr_on_snap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
